// File: rtl/ptr_mem_unit.sv
// ptr_mem_unit: pointer-pair byte load/store over a req/ack bus with register write-back
// and pointer post-increment / pre-decrement strobes for the register file.
module ptr_mem_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        op_valid,
   output logic        op_ready,
   input  logic        op_load,
   input  logic [1:0]  op_mode,
   input  logic [3:0]  op_rd,
   input  logic [3:0]  op_ptr,
   input  logic [7:0]  ptr_lo,
   input  logic [7:0]  ptr_hi,
   input  logic [7:0]  st_data,
   output logic        mem_req,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic        mem_ack,
   input  logic [7:0]  mem_rdata,
   output logic        rf_we,
   output logic [3:0]  rf_wsel,
   output logic [7:0]  rf_wdata,
   output logic        rf_inc,
   output logic        rf_dec,
   output logic [3:0]  rf_psel,
   output logic        done,
   output logic        err,
   output logic        conflict
);
   typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
   state_t      state;
   logic        ld_q;
   logic        conf_q;
   logic [1:0]  mode_q;
   logic [3:0]  rd_q;
   logic [3:0]  pair_q;
   logic [15:0] cnt;
   logic [15:0] addr_n;
   logic        conf_n;
   logic        finish;
   always_comb begin
      addr_n = (op_mode == 2'b10) ? {ptr_hi, ptr_lo} - 16'd1 : {ptr_hi, ptr_lo};
      conf_n = op_load && (op_rd[3:1] == op_ptr[3:1]) && (op_mode == 2'b01 || op_mode == 2'b10);
      finish = mem_ack || (cnt == TMO_LAST);
   end
   // A conflicting load keeps its data write; only the pointer strobe is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         op_ready  <= 1'b1;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rf_we     <= 1'b0;
         rf_wsel   <= '0;
         rf_wdata  <= '0;
         rf_inc    <= 1'b0;
         rf_dec    <= 1'b0;
         rf_psel   <= '0;
         done      <= 1'b0;
         err       <= 1'b0;
         conflict  <= 1'b0;
         ld_q      <= 1'b0;
         conf_q    <= 1'b0;
         mode_q    <= '0;
         rd_q      <= '0;
         pair_q    <= '0;
         cnt       <= '0;
      end else begin
         done     <= 1'b0;
         err      <= 1'b0;
         conflict <= 1'b0;
         rf_we    <= 1'b0;
         rf_inc   <= 1'b0;
         rf_dec   <= 1'b0;
         case (state)
            IDLE: if (op_valid) begin
               state     <= ISSUE;
               op_ready  <= 1'b0;
               mem_req   <= 1'b1;
               mem_we    <= !op_load;
               mem_addr  <= addr_n;
               mem_wdata <= st_data;
               ld_q      <= op_load;
               conf_q    <= conf_n;
               mode_q    <= op_mode;
               rd_q      <= op_rd;
               pair_q    <= op_ptr & 4'b1110;
               cnt       <= '0;
            end
            ISSUE: if (finish) begin
               state    <= WB;
               mem_req  <= 1'b0;
               done     <= 1'b1;
               err      <= !mem_ack;
               conflict <= conf_q;
               rf_we    <= ld_q && mem_ack;
               rf_wsel  <= rd_q;
               rf_wdata <= mem_rdata;
               rf_inc   <= mem_ack && !conf_q && mode_q == 2'b01;
               rf_dec   <= mem_ack && !conf_q && mode_q == 2'b10;
               rf_psel  <= pair_q;
            end else begin
               cnt <= cnt + 16'd1;
            end
            WB: begin
               state    <= IDLE;
               op_ready <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               op_ready <= 1'b1;
               mem_req  <= 1'b0;
            end
         endcase
      end
   end
endmodule
